regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (WE3/AD3/WD3) between two writeback requesters:
  - P: the in-order pipeline writeback stage.
  - L: a long-latency unit (load/multiply/divide return path).
- Fixed priority to P, with a starvation counter that forces an L grant after a bounded wait.
- Write-port outputs are registered and drive the register file write port directly.
- Writes to x0 are accepted and discarded, never presented to the register file.

---
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between the pipeline (P) and a long-latency unit (L).
// Optional statistics counters are enabled by defining WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_valid,
  output logic        p_ready,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [4:0]  l_addr,
  input  logic [31:0] l_data,
  output logic        we3,
  output logic [4:0]  ad3,
  output logic [31:0] wd3,
  output logic        starved
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] conflict_cnt,
  output logic [31:0] force_cnt,
  output logic [15:0] x0_drop_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  r_wait_cnt;
  logic        r_we3;
  logic [4:0]  r_ad3;
  logic [31:0] r_wd3;

  logic        w_force;
  logic        w_p_xfer;
  logic        w_l_xfer;
  logic [4:0]  w_win_addr;
  logic [31:0] w_win_data;

  // Grant depends only on the valids and the wait counter, never on data.
  always_comb begin
    w_force = (r_wait_cnt == LIMIT);
    p_ready = 1'b0;
    l_ready = 1'b0;
    starved = 1'b0;
    if (w_force && l_valid) begin
      l_ready = 1'b1;
      starved = 1'b1;
    end else if (p_valid) begin
      p_ready = 1'b1;
    end else if (l_valid) begin
      l_ready = 1'b1;
    end
  end

  always_comb begin
    w_p_xfer   = p_valid & p_ready;
    w_l_xfer   = l_valid & l_ready;
    w_win_addr = w_p_xfer ? p_addr : l_addr;
    w_win_data = w_p_xfer ? p_data : l_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= 4'd0;
    end else if (l_valid && !l_ready) begin
      r_wait_cnt <= (r_wait_cnt == LIMIT) ? LIMIT : r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  // Write-port stage: x0 writes complete the handshake but never raise we3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we3 <= 1'b0;
      r_ad3 <= 5'd0;
      r_wd3 <= 32'd0;
    end else if (w_p_xfer || w_l_xfer) begin
      r_we3 <= (w_win_addr != 5'd0);
      r_ad3 <= w_win_addr;
      r_wd3 <= w_win_data;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign we3 = r_we3;
  assign ad3 = r_ad3;
  assign wd3 = r_wd3;

`ifdef WB_ARB_STATS_EN
  logic [31:0] r_conflict_cnt;
  logic [31:0] r_force_cnt;
  logic [15:0] r_x0_drop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflict_cnt <= 32'd0;
      r_force_cnt    <= 32'd0;
      r_x0_drop_cnt  <= 16'd0;
    end else begin
      if (p_valid && l_valid && (r_conflict_cnt != 32'hFFFF_FFFF))
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      if (starved && (r_force_cnt != 32'hFFFF_FFFF))
        r_force_cnt <= r_force_cnt + 32'd1;
      if ((w_p_xfer || w_l_xfer) && (w_win_addr == 5'd0) && (r_x0_drop_cnt != 16'hFFFF))
        r_x0_drop_cnt <= r_x0_drop_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign force_cnt    = r_force_cnt;
  assign x0_drop_cnt  = r_x0_drop_cnt;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table for grants, queue of expected writes for the port.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_valid, l_valid;
  logic        p_ready, l_ready;
  logic [4:0]  p_addr, l_addr;
  logic [31:0] p_data, l_data;
  logic        we3;
  logic [4:0]  ad3;
  logic [31:0] wd3;
  logic        starved;
`ifdef WB_ARB_STATS_EN
  logic [31:0] conflict_cnt, force_cnt;
  logic [15:0] x0_drop_cnt;
`endif

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_data(p_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_addr(l_addr), .l_data(l_data),
    .we3(we3), .ad3(ad3), .wd3(wd3), .starved(starved)
`ifdef WB_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .force_cnt(force_cnt), .x0_drop_cnt(x0_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        e_prdy;
    logic        e_lrdy;
    logic        e_starved;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  ad;
    logic [31:0] wd;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    p_valid = pv; p_addr = pa; p_data = pd;
    l_valid = lv; l_addr = la; l_data = ld;
  endtask

  task automatic add(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld,
                     input logic ep, input logic el, input logic es);
    vec_t v;
    v.pv = pv; v.pa = pa; v.pd = pd; v.lv = lv; v.la = la; v.ld = ld;
    v.e_prdy = ep; v.e_lrdy = el; v.e_starved = es;
    vecs.push_back(v);
  endtask

  task automatic pop_check(input string tag);
    wr_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, " we3"}, {31'd0, we3}, {31'd0, e.we});
      if (e.we) begin
        chk({tag, " ad3"}, {27'd0, ad3}, {27'd0, e.ad});
        chk({tag, " wd3"}, wd3, e.wd);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t w;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Vector table: starting from reset state with STARVE_LIMIT = 4.
    add(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 1, 0, 0);          // P only
    add(0, 5'd0, 32'd0,        0, 5'd0, 32'd0, 0, 0, 0);          // idle
    for (int r = 0; r < 2; r++) begin                             // contention, two rounds
      for (int k = 0; k < 4; k++)
        add(1, 5'(k + 1), 32'(100 * r + k), 1, 5'd7, 32'h11, 1, 0, 0);
      add(1, 5'd6, 32'h66, 1, 5'd7, 32'h11, 0, 1, 1);
    end
    add(0, 5'd0, 32'd0,        0, 5'd0,  32'd0,        0, 0, 0);  // idle
    add(0, 5'd0, 32'd0,        1, 5'd0,  32'hFFFFFFFF, 0, 1, 0);  // x0 drop
    add(1, 5'd10, 32'hA,       1, 5'd10, 32'hB,        1, 0, 0);  // same address
    add(0, 5'd0, 32'd0,        1, 5'd10, 32'hB,        0, 1, 0);
    add(1, 5'd3, 32'h100,      1, 5'd9,  32'h99,       1, 0, 0);  // hold: L refused twice
    add(1, 5'd4, 32'h200,      1, 5'd9,  32'h99,       1, 0, 0);
    add(0, 5'd0, 32'd0,        1, 5'd9,  32'h99,       0, 1, 0);
    add(0, 5'd0, 32'd0,        0, 5'd0,  32'd0,        0, 0, 0);  // no duplicate pulse
    add(0, 5'd0, 32'd0,        1, 5'd12, 32'h55,       0, 1, 0);  // L alone goes at once

    repeat (2) @(posedge clk);
    #1;
    chk("reset we3", {31'd0, we3}, 32'd0);
    chk("reset ad3", {27'd0, ad3}, 32'd0);
    chk("reset wd3", wd3, 32'd0);
    chk("reset starved", {31'd0, starved}, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld);
      #2;
      chk($sformatf("v%0d p_ready", i), {31'd0, p_ready}, {31'd0, vecs[i].e_prdy});
      chk($sformatf("v%0d l_ready", i), {31'd0, l_ready}, {31'd0, vecs[i].e_lrdy});
      chk($sformatf("v%0d starved", i), {31'd0, starved}, {31'd0, vecs[i].e_starved});
      if (vecs[i].e_prdy) begin
        w.we = (vecs[i].pa != 0); w.ad = vecs[i].pa; w.wd = vecs[i].pd;
      end else if (vecs[i].e_lrdy) begin
        w.we = (vecs[i].la != 0); w.ad = vecs[i].la; w.wd = vecs[i].ld;
      end else begin
        w.we = 1'b0; w.ad = 5'd0; w.wd = 32'd0;
      end
      sb.push_back(w);
      @(posedge clk);
      #1;
      pop_check($sformatf("v%0d", i));
    end

`ifdef WB_ARB_STATS_EN
    chk("x0_drop_cnt", {16'd0, x0_drop_cnt}, 32'd1);
    chk("force_cnt", force_cnt, 32'd2);
`endif

    // Asynchronous reset in the middle of an L wait (wait count at 3).
    drive(1, 5'd1, 32'h1, 1, 5'd7, 32'h11);
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset we3", {31'd0, we3}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("async rst we3", {31'd0, we3}, 32'd0);
    chk("async rst ad3", {27'd0, ad3}, 32'd0);
    chk("async rst wd3", wd3, 32'd0);
    chk("async rst wait_cnt", {28'd0, dut.r_wait_cnt}, 32'd0);
    chk("in-reset p_ready", {31'd0, p_ready}, 32'd1);
    chk("in-reset starved", {31'd0, starved}, 32'd0);
    @(posedge clk);
    #1;
    chk("in-reset no write", {31'd0, we3}, 32'd0);
    rst = 1'b1;

    // After release the full wait window restarts from zero.
    for (int k = 0; k < 5; k++) begin
      #2;
      chk($sformatf("post-rst c%0d p_ready", k), {31'd0, p_ready}, (k < 4) ? 32'd1 : 32'd0);
      chk($sformatf("post-rst c%0d starved", k), {31'd0, starved}, (k < 4) ? 32'd0 : 32'd1);
      if (k < 4) begin
        w.we = 1'b1; w.ad = 5'd1; w.wd = 32'h1;
      end else begin
        w.we = 1'b1; w.ad = 5'd7; w.wd = 32'h11;
      end
      sb.push_back(w);
      @(posedge clk);
      #1;
      pop_check($sformatf("post-rst c%0d", k));
    end
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("final idle we3", {31'd0, we3}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
